paddle_ctrl: RTL and testbench
==============================

PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameters (name, default, meaning): SCREEN_W, 640, playfield width in pixels; PADDLE_W, 64, paddle width in pixels; X_INIT, 288, paddle left-edge x after reset or recentre; STEP, 2, pixels per move tick at normal speed; FAST_STEP, 6, pixels per move tick at fast speed; TICK_DIV, 250000, clk cycles per move tick (200 Hz at 50 MHz); ACCEL_TICKS, 20, consecutive held move ticks before fast speed.
REQ-002 Ports (name direction width meaning): clk in 1 system clock; reset in 1 reset; L in 1 left-arrow held (level, from keyboard stage); R in 1 right-arrow held (level); enable in 1 game running; recentre in 1 single-cycle pulse, return paddle to X_INIT; x_pos out 10 paddle left-edge x; moving_l out 1 paddle moving left; moving_r out 1 paddle moving right; at_left out 1 x_pos == 0; at_right out 1 x_pos == SCREEN_W-PADDLE_W.
REQ-003 Reset reset is synchronous, active-high; clock clk; all state updates on posedge clk.

Function
REQ-004 Tick counter counts 0..TICK_DIV-1 and wraps; tick is asserted for exactly the one cycle in which the counter equals TICK_DIV-1; the counter runs regardless of enable.
REQ-005 Direction request: dir = LEFT if L & ~R, RIGHT if R & ~L, NONE otherwise (L & R together = NONE).
REQ-006 FSM states: STOP, SLOW_L, SLOW_R, FAST_L, FAST_R; transitions evaluated only on tick cycles, except REQ-011/REQ-012.
REQ-007 STOP: on tick, dir LEFT -> SLOW_L, RIGHT -> SLOW_R, NONE -> stay; no position change on the entering tick.
REQ-008 SLOW_x: on tick, if dir matches x -> move STEP and increment hold counter; hold counter reaching ACCEL_TICKS -> FAST_x on the same tick; dir NONE -> STOP; dir opposite -> SLOW_opposite with hold counter cleared, no move that tick.
REQ-009 FAST_x: on tick, dir matches -> move FAST_STEP; NONE -> STOP; opposite -> SLOW_opposite, hold counter cleared, no move.
REQ-010 Moves are clamped: left move sets x_pos = max(0, x_pos-step); right move sets x_pos = min(SCREEN_W-PADDLE_W, x_pos+step); arithmetic done in 11 bits, no wrap-around ever visible on x_pos.
REQ-011 enable low: state forced to STOP and hold counter cleared on the next clk edge; x_pos held; enable rising resumes from STOP.
REQ-012 recentre high: x_pos <= X_INIT, state <= STOP, hold counter cleared on that edge; recentre has priority over tick motion and enable.
REQ-013 Hold counter saturates at ACCEL_TICKS; clears whenever state enters STOP.
REQ-014 moving_l = state in {SLOW_L, FAST_L}; moving_r = state in {SLOW_R, FAST_R}; at_left/at_right are combinational compares of registered x_pos.
REQ-015 Latency: x_pos changes on the clk edge ending the tick cycle; outputs are registered or derived only from registers.

Reset
REQ-016 On reset: x_pos = X_INIT, state = STOP, hold counter = 0, tick counter = 0; moving_l = moving_r = 0, at_left = at_right = 0.
REQ-017 Reset has priority over recentre, enable and tick; reset mid-move returns to REQ-016 values on the next edge.

Verification (bench overrides TICK_DIV=4, ACCEL_TICKS=3)
REQ-018 Reset, enable=1, L=R=0 for 40 cycles -> x_pos stays 288, moving_l=moving_r=0.
REQ-019 Hold R from cycle 0 -> tick 1 enters SLOW_R (x=288), ticks 2..4 give 290, 292, 294, tick 4 enters FAST_R, tick 5 gives 300.
REQ-020 Hold L from reset until clamp -> x_pos steps down and stops at 0 exactly, at_left=1, no underflow; release L -> STOP on next tick.
REQ-021 Hold R until clamp -> x_pos saturates at 576, at_right=1; assert L and R together -> STOP on next tick, x_pos unchanged.
REQ-022 While FAST_L, pulse recentre -> next edge x_pos=288, moving_l=0; while FAST_R, drop enable -> STOP next edge, x_pos frozen until enable returns.
REQ-023 In SLOW_L switch to R (L low) -> next tick enters SLOW_R with no move, hold counter 0; following tick moves +2.

Source files
------------

// File: rtl/paddle_ctrl.sv
// Paddle position controller for a Breakout-style playfield.
// Converts held left/right keys into paddle motion on a fixed move tick, with a slow phase
// that switches to fast motion after the key has been held for ACCEL_TICKS move ticks.
// The position is clamped to the playfield; recentre and enable override tick motion.
module paddle_ctrl #(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned PADDLE_W    = 64,
    parameter int unsigned X_INIT      = 288,
    parameter int unsigned STEP        = 2,
    parameter int unsigned FAST_STEP   = 6,
    parameter int unsigned TICK_DIV    = 250000,
    parameter int unsigned ACCEL_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L,
    input  logic       R,
    input  logic       enable,
    input  logic       recentre,
    output logic [9:0] x_pos,
    output logic       moving_l,
    output logic       moving_r,
    output logic       at_left,
    output logic       at_right
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HOLD_W = (ACCEL_TICKS > 0) ? $clog2(ACCEL_TICKS + 1) : 1;

    localparam logic [TICK_W-1:0] LP_TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] LP_ACCEL     = HOLD_W'(ACCEL_TICKS);
    localparam logic [10:0]       LP_X_MAX     = 11'(SCREEN_W - PADDLE_W);
    localparam logic [9:0]        LP_X_INIT    = 10'(X_INIT);
    localparam logic [9:0]        LP_STEP      = 10'(STEP);
    localparam logic [9:0]        LP_FAST_STEP = 10'(FAST_STEP);

    typedef enum logic [2:0] {
        StStop  = 3'd0,
        StSlowL = 3'd1,
        StSlowR = 3'd2,
        StFastL = 3'd3,
        StFastR = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        DirNone  = 2'd0,
        DirLeft  = 2'd1,
        DirRight = 2'd2
    } dir_e;

    // Registered state
    logic [TICK_W-1:0] r_tick_cnt;
    state_e            r_state;
    logic [HOLD_W-1:0] r_hold;
    logic [9:0]        r_x_pos;

    // Next-state and helper signals
    logic              w_tick;
    dir_e              w_dir;
    state_e            w_state_d;
    logic [HOLD_W-1:0] w_hold_d;
    logic [HOLD_W-1:0] w_hold_inc;
    logic [9:0]        w_x_d;
    logic [9:0]        w_step;
    logic [9:0]        w_x_left;
    logic [10:0]       w_sum;
    logic [9:0]        w_x_right;

    // Move tick divider, free-running regardless of enable
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == LP_TICK_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick = (r_tick_cnt == LP_TICK_LAST);

    // Decode key levels into a direction request; both keys held cancels out
    always_comb begin
        w_dir = DirNone;
        if (L && !R) begin
            w_dir = DirLeft;
        end else if (R && !L) begin
            w_dir = DirRight;
        end
    end

    // Clamped candidate positions for a left or right move at the current speed
    always_comb begin
        w_step    = (r_state == StFastL || r_state == StFastR) ? LP_FAST_STEP : LP_STEP;
        w_x_left  = (r_x_pos >= w_step) ? (r_x_pos - w_step) : 10'd0;
        w_sum     = {1'b0, r_x_pos} + {1'b0, w_step};
        w_x_right = (w_sum > LP_X_MAX) ? LP_X_MAX[9:0] : w_sum[9:0];
    end

    // Saturating increment of the key-hold counter
    always_comb begin
        w_hold_inc = r_hold;
        if (r_hold != LP_ACCEL) begin
            w_hold_inc = r_hold + 1'b1;
        end
    end

    // Next-state logic: recentre beats enable, enable beats tick motion
    always_comb begin
        w_state_d = r_state;
        w_hold_d  = r_hold;
        w_x_d     = r_x_pos;
        if (recentre) begin
            w_state_d = StStop;
            w_hold_d  = '0;
            w_x_d     = LP_X_INIT;
        end else if (!enable) begin
            w_state_d = StStop;
            w_hold_d  = '0;
        end else if (w_tick) begin
            unique case (r_state)
                StStop: begin
                    // Entering a slow state does not move on the entering tick
                    w_hold_d = '0;
                    if (w_dir == DirLeft) begin
                        w_state_d = StSlowL;
                    end else if (w_dir == DirRight) begin
                        w_state_d = StSlowR;
                    end
                end
                StSlowL: begin
                    if (w_dir == DirLeft) begin
                        w_x_d    = w_x_left;
                        w_hold_d = w_hold_inc;
                        if (w_hold_inc == LP_ACCEL) begin
                            w_state_d = StFastL;
                        end
                    end else if (w_dir == DirRight) begin
                        w_state_d = StSlowR;
                        w_hold_d  = '0;
                    end else begin
                        w_state_d = StStop;
                        w_hold_d  = '0;
                    end
                end
                StSlowR: begin
                    if (w_dir == DirRight) begin
                        w_x_d    = w_x_right;
                        w_hold_d = w_hold_inc;
                        if (w_hold_inc == LP_ACCEL) begin
                            w_state_d = StFastR;
                        end
                    end else if (w_dir == DirLeft) begin
                        w_state_d = StSlowL;
                        w_hold_d  = '0;
                    end else begin
                        w_state_d = StStop;
                        w_hold_d  = '0;
                    end
                end
                StFastL: begin
                    if (w_dir == DirLeft) begin
                        w_x_d    = w_x_left;
                        w_hold_d = w_hold_inc;
                    end else if (w_dir == DirRight) begin
                        w_state_d = StSlowR;
                        w_hold_d  = '0;
                    end else begin
                        w_state_d = StStop;
                        w_hold_d  = '0;
                    end
                end
                StFastR: begin
                    if (w_dir == DirRight) begin
                        w_x_d    = w_x_right;
                        w_hold_d = w_hold_inc;
                    end else if (w_dir == DirLeft) begin
                        w_state_d = StSlowL;
                        w_hold_d  = '0;
                    end else begin
                        w_state_d = StStop;
                        w_hold_d  = '0;
                    end
                end
                default: begin
                    // Unreachable encodings recover to a safe stopped state
                    w_state_d = StStop;
                    w_hold_d  = '0;
                end
            endcase
        end
    end

    // State, hold counter and position registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StStop;
            r_hold  <= '0;
            r_x_pos <= LP_X_INIT;
        end else begin
            r_state <= w_state_d;
            r_hold  <= w_hold_d;
            r_x_pos <= w_x_d;
        end
    end

    // Outputs derived only from registered state
    assign x_pos    = r_x_pos;
    assign moving_l = (r_state == StSlowL) || (r_state == StFastL);
    assign moving_r = (r_state == StSlowR) || (r_state == StFastR);
    assign at_left  = (r_x_pos == 10'd0);
    assign at_right = (r_x_pos == LP_X_MAX[9:0]);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed testbench for paddle_ctrl with TICK_DIV=4 and ACCEL_TICKS=3.
// Ticks land on every 4th clock edge after the reset edge; phase tracks that alignment.
module tb_paddle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       L;
    logic       R;
    logic       enable;
    logic       recentre;
    logic [9:0] x_pos;
    logic       moving_l;
    logic       moving_r;
    logic       at_left;
    logic       at_right;

    int total = 0;
    int bad   = 0;
    int phase = 0;

    paddle_ctrl #(
        .SCREEN_W   (640),
        .PADDLE_W   (64),
        .X_INIT     (288),
        .STEP       (2),
        .FAST_STEP  (6),
        .TICK_DIV   (4),
        .ACCEL_TICKS(3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .L       (L),
        .R       (R),
        .enable  (enable),
        .recentre(recentre),
        .x_pos   (x_pos),
        .moving_l(moving_l),
        .moving_r(moving_r),
        .at_left (at_left),
        .at_right(at_right)
    );

    always #5 clk = ~clk;

    // Advance n clock edges and sample 1 time unit after the last one
    task automatic clk_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            phase = (phase + 1) % 4;
        end
        #1;
    endtask

    // Advance through the next n tick edges
    task automatic ticks(input int n);
        repeat (n) clk_edges(4 - phase);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        L        = 1'b0;
        R        = 1'b0;
        enable   = 1'b1;
        recentre = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        phase = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (x_pos !== 10'd288) begin bad++; $display("FAIL reset_x got=%0d exp=288", x_pos); end
        total++; if ({moving_l, moving_r} !== 2'b00) begin bad++; $display("FAIL reset_moving got=%b exp=00", {moving_l, moving_r}); end
        total++; if ({at_left, at_right} !== 2'b00) begin bad++; $display("FAIL reset_at got=%b exp=00", {at_left, at_right}); end
        // Tick counter restarts at 0: first tick edge is the 4th after reset
        R = 1'b1;
        clk_edges(3);
        total++; if (moving_r !== 1'b0) begin bad++; $display("FAIL tick_early got=%b exp=0", moving_r); end
        clk_edges(1);
        total++; if (moving_r !== 1'b1 || x_pos !== 10'd288) begin bad++; $display("FAIL tick_first got=%b/%0d exp=1/288", moving_r, x_pos); end
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            ticks(1);
            total++; if (x_pos !== 10'd288 || moving_l !== 1'b0 || moving_r !== 1'b0) begin
                bad++; $display("FAIL idle_%0d got=%0d/%b%b exp=288/00", i, x_pos, moving_l, moving_r);
            end
        end
    endtask

    task automatic test_accel();
        do_reset();
        R = 1'b1;
        ticks(1);
        total++; if (x_pos !== 10'd288 || moving_r !== 1'b1) begin bad++; $display("FAIL accel_enter got=%0d/%b exp=288/1", x_pos, moving_r); end
        ticks(1);
        total++; if (x_pos !== 10'd290) begin bad++; $display("FAIL accel_t2 got=%0d exp=290", x_pos); end
        clk_edges(3);
        total++; if (x_pos !== 10'd290) begin bad++; $display("FAIL accel_offtick got=%0d exp=290", x_pos); end
        clk_edges(1);
        total++; if (x_pos !== 10'd292) begin bad++; $display("FAIL accel_t3 got=%0d exp=292", x_pos); end
        ticks(1);
        total++; if (x_pos !== 10'd294) begin bad++; $display("FAIL accel_t4 got=%0d exp=294", x_pos); end
        ticks(1);
        total++; if (x_pos !== 10'd300) begin bad++; $display("FAIL accel_t5 got=%0d exp=300", x_pos); end
    endtask

    task automatic test_left_clamp();
        do_reset();
        R = 1'b1;
        ticks(2);
        R = 1'b0;
        L = 1'b1;
        ticks(1);
        total++; if (x_pos !== 10'd290 || moving_l !== 1'b1) begin bad++; $display("FAIL lclamp_rev got=%0d/%b exp=290/1", x_pos, moving_l); end
        ticks(3);
        total++; if (x_pos !== 10'd284) begin bad++; $display("FAIL lclamp_slow got=%0d exp=284", x_pos); end
        ticks(47);
        total++; if (x_pos !== 10'd2 || at_left !== 1'b0) begin bad++; $display("FAIL lclamp_near got=%0d/%b exp=2/0", x_pos, at_left); end
        ticks(1);
        total++; if (x_pos !== 10'd0 || at_left !== 1'b1) begin bad++; $display("FAIL lclamp_edge got=%0d/%b exp=0/1", x_pos, at_left); end
        ticks(2);
        total++; if (x_pos !== 10'd0 || moving_l !== 1'b1) begin bad++; $display("FAIL lclamp_hold got=%0d/%b exp=0/1", x_pos, moving_l); end
        L = 1'b0;
        ticks(1);
        total++; if (x_pos !== 10'd0 || moving_l !== 1'b0) begin bad++; $display("FAIL lclamp_release got=%0d/%b exp=0/0", x_pos, moving_l); end
    endtask

    task automatic test_right_clamp();
        do_reset();
        R = 1'b1;
        ticks(50);
        total++; if (x_pos !== 10'd570 || at_right !== 1'b0) begin bad++; $display("FAIL rclamp_near got=%0d/%b exp=570/0", x_pos, at_right); end
        ticks(1);
        total++; if (x_pos !== 10'd576 || at_right !== 1'b1) begin bad++; $display("FAIL rclamp_edge got=%0d/%b exp=576/1", x_pos, at_right); end
        ticks(5);
        total++; if (x_pos !== 10'd576 || moving_r !== 1'b1) begin bad++; $display("FAIL rclamp_hold got=%0d/%b exp=576/1", x_pos, moving_r); end
        L = 1'b1;
        ticks(1);
        total++; if (x_pos !== 10'd576 || moving_r !== 1'b0 || moving_l !== 1'b0) begin
            bad++; $display("FAIL rclamp_both got=%0d/%b%b exp=576/00", x_pos, moving_l, moving_r);
        end
    endtask

    task automatic test_recentre_enable();
        do_reset();
        L = 1'b1;
        ticks(6);
        total++; if (x_pos !== 10'd270) begin bad++; $display("FAIL fastl_pos got=%0d exp=270", x_pos); end
        clk_edges(1);
        recentre = 1'b1;
        clk_edges(1);
        recentre = 1'b0;
        total++; if (x_pos !== 10'd288 || moving_l !== 1'b0) begin bad++; $display("FAIL recentre got=%0d/%b exp=288/0", x_pos, moving_l); end
        ticks(1);
        total++; if (x_pos !== 10'd288 || moving_l !== 1'b1) begin bad++; $display("FAIL recentre_resume got=%0d/%b exp=288/1", x_pos, moving_l); end

        do_reset();
        R = 1'b1;
        ticks(5);
        total++; if (x_pos !== 10'd300 || moving_r !== 1'b1) begin bad++; $display("FAIL fastr_pos got=%0d/%b exp=300/1", x_pos, moving_r); end
        clk_edges(1);
        enable = 1'b0;
        clk_edges(1);
        total++; if (x_pos !== 10'd300 || moving_r !== 1'b0) begin bad++; $display("FAIL disable got=%0d/%b exp=300/0", x_pos, moving_r); end
        ticks(3);
        total++; if (x_pos !== 10'd300 || moving_r !== 1'b0) begin bad++; $display("FAIL disable_hold got=%0d/%b exp=300/0", x_pos, moving_r); end
        enable = 1'b1;
        ticks(1);
        total++; if (x_pos !== 10'd300 || moving_r !== 1'b1) begin bad++; $display("FAIL enable_resume got=%0d/%b exp=300/1", x_pos, moving_r); end
        ticks(3);
        total++; if (x_pos !== 10'd306) begin bad++; $display("FAIL enable_slow got=%0d exp=306", x_pos); end
        ticks(1);
        total++; if (x_pos !== 10'd312) begin bad++; $display("FAIL enable_fast got=%0d exp=312", x_pos); end
        // Recentre still acts while disabled
        enable   = 1'b0;
        recentre = 1'b1;
        clk_edges(1);
        recentre = 1'b0;
        enable   = 1'b1;
        total++; if (x_pos !== 10'd288 || moving_r !== 1'b0) begin bad++; $display("FAIL recentre_dis got=%0d/%b exp=288/0", x_pos, moving_r); end
    endtask

    task automatic test_reverse();
        do_reset();
        L = 1'b1;
        ticks(2);
        total++; if (x_pos !== 10'd286) begin bad++; $display("FAIL rev_slowl got=%0d exp=286", x_pos); end
        L = 1'b0;
        R = 1'b1;
        ticks(1);
        total++; if (x_pos !== 10'd286 || moving_r !== 1'b1 || moving_l !== 1'b0) begin
            bad++; $display("FAIL rev_switch got=%0d/%b%b exp=286/01", x_pos, moving_l, moving_r);
        end
        ticks(1);
        total++; if (x_pos !== 10'd288) begin bad++; $display("FAIL rev_first got=%0d exp=288", x_pos); end
        ticks(2);
        total++; if (x_pos !== 10'd292) begin bad++; $display("FAIL rev_hold_cleared got=%0d exp=292", x_pos); end
        ticks(1);
        total++; if (x_pos !== 10'd298) begin bad++; $display("FAIL rev_fast got=%0d exp=298", x_pos); end
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        R = 1'b1;
        ticks(6);
        total++; if (x_pos !== 10'd306) begin bad++; $display("FAIL mid_pos got=%0d exp=306", x_pos); end
        reset    = 1'b1;
        recentre = 1'b0;
        @(posedge clk);
        #1;
        total++; if (x_pos !== 10'd288 || moving_r !== 1'b0) begin bad++; $display("FAIL mid_reset got=%0d/%b exp=288/0", x_pos, moving_r); end
        reset = 1'b0;
        phase = 0;
        ticks(1);
        total++; if (x_pos !== 10'd288 || moving_r !== 1'b1) begin bad++; $display("FAIL mid_resume got=%0d/%b exp=288/1", x_pos, moving_r); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_accel();
        test_left_clamp();
        test_right_clamp();
        test_recentre_enable();
        test_reverse();
        test_reset_mid_move();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "time limit reached");
    end

endmodule
